uart_tx_buf: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 / 115200 baud / 50 MHz transmitter. It adds configurable clock and baud, data width, parity and stop bits, an asynchronous reset, and a one-entry holding buffer with a valid/ready handshake, so consecutive frames go out back-to-back with no idle gap. It sits between any byte-producing logic and the serial `tx` pin.

---
 rtl/uart_tx_buf.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf -- parametrised UART transmitter with a one-word holding buffer.
//
// A word accepted on the valid/ready handshake waits in the holding buffer
// until the serialiser is free. When a frame's last stop cycle ends with the
// buffer full, the next start bit follows on the very next cycle.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate in bit/s (CPB = CLK_FREQ / BAUD, must be >= 2)
//   DATA_BITS  payload width, 5..9
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   clk_50M   in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   tx_en     in   data valid; transfer when tx_en && tx_ready
//   data      in   payload, sampled on a transfer
//   tx_ready  out  holding buffer empty
//   tx        out  serial line, idle high, registered
//   tx_busy   out  a frame is on the line
//   tx_done   out  one-cycle pulse on the final stop-bit cycle
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle; waits for the holding buffer to fill
// START  | start bit (low) for CPB cycles
// DATA   | payload bits, LSB first, CPB cycles each
// PARITY | parity bit for CPB cycles (skipped when PARITY == 0)
// STOP   | STOP_BITS stop bits (high); reloads straight into START if full
module uart_tx_buf #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50M,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_baud_cnt;
  logic [CW-1:0]        w_baud_nxt;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_nxt;
  logic                 r_stop_cnt;
  logic                 w_stop_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par;
  logic                 w_par_nxt;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_buf_valid;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_baud_last;
  logic                 w_bit_last;
  logic                 w_stop_last;

  assign w_baud_last = (r_baud_cnt == CW'(CPB - 1));
  assign w_bit_last  = (r_bit_cnt == BW'(DATA_BITS - 1));
  assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_accept    = tx_en && tx_ready;

  assign tx_ready = !r_buf_valid;
  assign tx       = r_tx;
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_done  = (r_state == S_STOP) && w_baud_last && w_stop_last;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt + CW'(1);
    w_bit_nxt   = r_bit_cnt;
    w_stop_nxt  = r_stop_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_load      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (r_buf_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (w_bit_last) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (w_stop_last) begin
            w_stop_nxt = 1'b0;
            // A full buffer chains straight into the next start bit.
            if (r_buf_valid) begin
              w_load      = 1'b1;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_stop_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_shift_nxt = r_buf;
      w_par_nxt   = (PARITY == 2) ? (^r_buf) : ~(^r_buf);
    end

    // tx is registered, so it is driven from the next-state view.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      // A new word wins over the load that frees the buffer on the same edge.
      if (w_accept) begin
        r_buf       <= data;
        r_buf_valid <= 1'b1;
      end else if (w_load) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf -- scoreboard bench for uart_tx_buf.
// Four instances cover the default 8N1 setup, even and odd parity, and a
// 7-bit / 2-stop configuration. Stimulus pushes hand-computed frame patterns
// (bit 0 = start bit, then data LSB first, parity, stop bits) into a queue;
// a monitor decodes the active instance's line and compares every cycle.
`timescale 1ns/1ps
module tb_uart_tx_buf;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst;
  logic [NI-1:0] tx_en;
  logic [7:0]    data [NI];
  wire  [NI-1:0] tx_ready;
  wire  [NI-1:0] tx;
  wire  [NI-1:0] tx_busy;
  wire  [NI-1:0] tx_done;

  uart_tx_buf u0 (
    .clk_50M(clk), .rst(rst[0]), .tx_en(tx_en[0]), .data(data[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx_buf #(.CLK_FREQ(1000), .BAUD(100), .PARITY(2)) u1 (
    .clk_50M(clk), .rst(rst[1]), .tx_en(tx_en[1]), .data(data[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx_buf #(.CLK_FREQ(1000), .BAUD(100), .PARITY(1)) u2 (
    .clk_50M(clk), .rst(rst[2]), .tx_en(tx_en[2]), .data(data[2]),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  uart_tx_buf #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk_50M(clk), .rst(rst[3]), .tx_en(tx_en[3]), .data(data[3][6:0]),
    .tx_ready(tx_ready[3]), .tx(tx[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur = 0;
  int cpb_a [NI] = '{434, 10, 10, 10};
  int nb_a  [NI] = '{10, 11, 11, 10};
  int done_cnt [NI] = '{default: 0};
  logic mon_busy = 1'b0;

  typedef struct {
    logic [15:0] frame;
    int          mode;   // 0 no timing check, 1 start one cycle after transfer, 2 back-to-back
    int          xcyc;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) for (int i = 0; i < NI; i++) if (tx_done[i]) done_cnt[i]++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic prev, v, last_v, aborted, done_ok, busy_ok;
    exp_t e;
    int start_c, last_start, nb, cpb, bad_bit;
    prev = 1'b1;
    last_start = -1;
    forever begin
      @(negedge clk);
      v = tx[cur];
      if (rst[cur]) begin
        prev = 1'b1;
      end else if (prev && !v) begin
        mon_busy = 1'b1;
        start_c = cyc;
        nb = nb_a[cur];
        cpb = cpb_a[cur];
        chk("frame queued at start bit", int'(q.size() > 0), 1);
        if (q.size() > 0) e = q.pop_front();
        else begin e.frame = '1; e.mode = 0; e.xcyc = 0; end
        if (e.mode == 1) chk("start bit latency", start_c - e.xcyc, 1);
        else if (e.mode == 2) chk("back-to-back start spacing", start_c - last_start, nb * cpb);
        last_start = start_c;
        aborted = 1'b0; done_ok = 1'b1; busy_ok = 1'b1; bad_bit = -1; last_v = v;
        for (int b = 0; b < nb && !aborted; b++)
          for (int c = 0; c < cpb && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst[cur]) aborted = 1'b1;
            else begin
              last_v = tx[cur];
              if (tx[cur] !== e.frame[b] && bad_bit < 0) bad_bit = b;
              if (tx_done[cur] !== (b == nb - 1 && c == cpb - 1)) done_ok = 1'b0;
              if (tx_busy[cur] !== 1'b1) busy_ok = 1'b0;
            end
          end
        if (!aborted) begin
          chk("frame first wrong bit position", bad_bit, -1);
          chk("tx_done only on last stop cycle", int'(done_ok), 1);
          chk("tx_busy through frame", int'(busy_ok), 1);
          prev = last_v;
        end else begin
          prev = 1'b1;
        end
        mon_busy = 1'b0;
      end else begin
        prev = v;
      end
    end
  end

  // Leaves tx_en high on return; the caller drops it or issues another word.
  task automatic xfer(input logic [7:0] w, input logic [15:0] fr, input int mode);
    int n;
    logic r;
    exp_t e;
    data[cur] = w;
    tx_en[cur] = 1'b1;
    n = 0;
    do begin
      r = tx_ready[cur];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 20000);
    chk("transfer accepted", int'(r), 1);
    e.frame = fr;
    e.mode  = mode;
    e.xcyc  = cyc;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || mon_busy || tx_busy[cur]) && n < 20000);
    chk(name, int'(n < 20000), 1);
  endtask

  int d;

  initial begin
    rst = '1;
    tx_en = '0;
    for (int i = 0; i < NI; i++) data[i] = 8'h00;
    #12;
    chk("reset tx", tx[0], 1);
    chk("reset tx_ready", tx_ready[0], 1);
    chk("reset tx_busy", tx_busy[0], 0);
    chk("reset tx_done", tx_done[0], 0);
    chk("reset tx all instances", int'(tx), 4'hF);
    @(negedge clk);
    rst = '0;
    repeat (3) @(negedge clk);

    // single 0x55 frame, default configuration
    cur = 0;
    d = done_cnt[0];
    xfer(8'h55, 16'h02AA, 1);
    tx_en[0] = 1'b0;
    chk("tx_ready low after transfer", tx_ready[0], 0);
    @(posedge clk); #1;
    chk("tx low with start bit", tx[0], 0);
    chk("tx_ready high after load", tx_ready[0], 1);
    chk("tx_busy high with start bit", tx_busy[0], 1);
    wait_idle("0x55 frame completes");
    chk("tx_busy low after frame", tx_busy[0], 0);
    chk("tx idle after frame", tx[0], 1);
    chk("one tx_done for 0x55", done_cnt[0] - d, 1);

    // two words with tx_en held high: no idle gap between frames
    d = done_cnt[0];
    xfer(8'hA3, 16'h0346, 1);
    xfer(8'h0F, 16'h021E, 2);
    tx_en[0] = 1'b0;
    chk("tx_ready low while buffer full", tx_ready[0], 0);
    repeat (2000) @(negedge clk);
    chk("tx_ready still low mid frame", tx_ready[0], 0);
    wait_idle("A3/0F frames complete");
    chk("two tx_done pulses", done_cnt[0] - d, 2);

    // even and odd parity on 0x07, plus odd parity on 0x00
    cur = 1;
    xfer(8'h07, 16'h060E, 1);
    tx_en[1] = 1'b0;
    wait_idle("even parity frame completes");
    cur = 2;
    xfer(8'h07, 16'h040E, 1);
    tx_en[2] = 1'b0;
    wait_idle("odd parity 0x07 completes");
    xfer(8'h00, 16'h0600, 1);
    tx_en[2] = 1'b0;
    wait_idle("odd parity 0x00 completes");

    // 7 data bits, 2 stop bits; bit 7 of 0xC1 never reaches the DUT
    cur = 3;
    d = done_cnt[3];
    xfer(8'hC1, 16'h0382, 1);
    tx_en[3] = 1'b0;
    wait_idle("7-bit 2-stop frame completes");
    chk("one tx_done 7-bit frame", done_cnt[3] - d, 1);

    // reset in the middle of the data bits with a word waiting in the buffer
    cur = 0;
    xfer(8'h00, 16'h0200, 1);
    xfer(8'h99, 16'h0332, 2);
    tx_en[0] = 1'b0;
    repeat (434 * 3) @(negedge clk);
    d = done_cnt[0];
    #1 rst[0] = 1'b1;
    #1;
    chk("tx high at once on reset", tx[0], 1);
    chk("tx_ready high on reset", tx_ready[0], 1);
    chk("tx_busy low on reset", tx_busy[0], 0);
    q.delete();
    repeat (5) @(negedge clk);
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("no tx_done for aborted frame", done_cnt[0] - d, 0);
    xfer(8'h3C, 16'h0278, 1);
    tx_en[0] = 1'b0;
    wait_idle("0x3C after reset completes");
    chk("one tx_done after reset", done_cnt[0] - d, 1);

    // four words streamed with tx_en held, even parity
    cur = 1;
    d = done_cnt[1];
    xfer(8'h00, 16'h0400, 1);
    xfer(8'hFF, 16'h05FE, 2);
    chk("tx_ready low after second word", tx_ready[1], 0);
    xfer(8'h81, 16'h0502, 2);
    xfer(8'h80, 16'h0700, 2);
    tx_en[1] = 1'b0;
    wait_idle("stream completes");
    chk("four tx_done pulses", done_cnt[1] - d, 4);

    chk("expected queue drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
